// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle multiply/divide unit with a private HI/LO pair.
// It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time through a
// valid/ready handshake and commits results to HI/LO unless a flush cancels
// the operation first.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high
//   req_valid  request present
//   req_ready  request can be accepted (= !busy && !cancel)
//   req_op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   req_src1   multiplicand / dividend / MTHI-MTLO data
//   req_src2   multiplier / divisor
//   cancel     exception flush; abandons any in-flight operation
//   busy       operation in flight (HI/LO stale)
//   done       one-cycle pulse after a HI/LO commit
//   hi, lo     HI and LO registers
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW_DIV = $clog2(WIDTH) + 1;
  localparam int unsigned CW_MUL = $clog2(MUL_STAGES) + 1;
  localparam int unsigned CNT_W  = (CW_DIV > CW_MUL) ? CW_DIV : CW_MUL;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Multiplier operands, extended to WIDTH+1 bits at acceptance.
  logic [WIDTH:0]   mul_a;
  logic [WIDTH:0]   mul_b;

  // Divider working registers.
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dvnd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             accept;
  logic             div_signed;
  logic             s1_neg;
  logic             s2_neg;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [2*WIDTH-1:0] mul_a_ext;
  logic [2*WIDTH-1:0] mul_b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign req_ready = !busy && !cancel;
  assign accept    = req_valid && req_ready;

  always_comb begin
    div_signed = (req_op == 3'd2);
    s1_neg     = div_signed && req_src1[WIDTH-1];
    s2_neg     = div_signed && req_src2[WIDTH-1];
    abs1       = s1_neg ? -req_src1 : req_src1;
    abs2       = s2_neg ? -req_src2 : req_src2;

    // Low 2*WIDTH bits of the product of the WIDTH+1-bit extended operands.
    mul_a_ext  = {{(WIDTH-1){mul_a[WIDTH]}}, mul_a};
    mul_b_ext  = {{(WIDTH-1){mul_b[WIDTH]}}, mul_b};
    prod       = mul_a_ext * mul_b_ext;

    // One restoring step: a borrow out of diff means restore.
    shifted    = {rem, quot[WIDTH-1]};
    diff       = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      quot     <= '0;
      rem      <= '0;
      dvsr     <= '0;
      dvnd_raw <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (req_op)
                3'd0, 3'd1: begin
                  mul_a <= {(req_op == 3'd0) && req_src1[WIDTH-1], req_src1};
                  mul_b <= {(req_op == 3'd0) && req_src2[WIDTH-1], req_src2};
                  cnt   <= MUL_LOAD;
                  state <= S_MUL;
                  busy  <= 1'b1;
                end
                3'd2, 3'd3: begin
                  quot     <= abs1;
                  rem      <= '0;
                  dvsr     <= abs2;
                  dvnd_raw <= req_src1;
                  neg_q    <= s1_neg ^ s2_neg;
                  neg_r    <= s1_neg;
                  div_zero <= (req_src2 == '0);
                  cnt      <= DIV_LOAD;
                  state    <= S_DIV;
                  busy     <= 1'b1;
                end
                3'd4: begin
                  hi   <= req_src1;
                  done <= 1'b1;
                end
                3'd5: begin
                  lo   <= req_src1;
                  done <= 1'b1;
                end
                default: done <= 1'b1;
              endcase
            end
          end
          S_MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= prod;
              state    <= S_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_DIV: begin
            quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
            rem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            if (cnt == '0) begin
              state <= S_FIX;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_FIX: begin
            // Signed overflow needs no special case: |MIN|/1 = 2^(W-1) and
            // negating it wraps back to the same pattern, remainder 0.
            if (div_zero) begin
              lo <= '1;
              hi <= dvnd_raw;
            end else begin
              lo <= neg_q ? -quot : quot;
              hi <= neg_r ? -rem : rem;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit (WIDTH=32 and WIDTH=16).
module tb_muldiv_hilo_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        w_valid;
  logic        w_ready;
  logic [2:0]  w_op;
  logic [15:0] w_src1;
  logic [15:0] w_src2;
  logic        w_cancel;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_hi;
  logic [15:0] w_lo;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_hilo_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  muldiv_hilo_unit #(.WIDTH(16), .MUL_STAGES(2)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (w_valid),
    .req_ready (w_ready),
    .req_op    (w_op),
    .req_src1  (w_src1),
    .req_src2  (w_src2),
    .cancel    (w_cancel),
    .busy      (w_busy),
    .done      (w_done),
    .hi        (w_hi),
    .lo        (w_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle and follow it to its done cycle.
  // lat = edges from acceptance to the HI/LO commit. Operand buses are
  // scrambled right after acceptance to show they are not re-sampled.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int unsigned lat,
                       input logic [31:0] e_hi, input logic [31:0] e_lo);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    check({tag, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_src1  = ~a;
    req_src2  = ~b;
    for (int unsigned i = 1; i <= lat; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nodone"}, done, 0);
      check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      tick();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busyoff"}, busy, 0);
    check({tag, "_hi"}, hi, e_hi);
    check({tag, "_lo"}, lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  // Start a DIV, cancel it in cycle cyc after acceptance, and confirm nothing
  // is committed afterwards.
  task automatic cancel_div(input string tag, input int unsigned cyc);
    int unsigned pulses;
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_src1  = 32'hFFFF_FFF9;
    req_src2  = 32'h0000_0002;
    tick();
    req_valid = 1'b0;
    for (int unsigned i = 1; i < cyc; i++) tick();
    cancel = 1'b1;
    #1;
    check({tag, "_ready_lo"}, req_ready, 0);
    tick();
    cancel = 1'b0;
    #1;
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hilo"}, {hi, lo}, {32'h11, 32'h22});
    pulses = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    check({tag, "_nodone"}, pulses, 0);
    check({tag, "_hilo_late"}, {hi, lo}, {32'h11, 32'h22});
  endtask

  initial begin
    int unsigned pulses;
    checks    = 0;
    errors    = 0;
    m_hi      = '0;
    m_lo      = '0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_src1  = '0;
    req_src2  = '0;
    cancel    = 1'b0;
    w_valid   = 1'b0;
    w_op      = '0;
    w_src1    = '0;
    w_src2    = '0;
    w_cancel  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 1);

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // MTLO accepted in the MULT done cycle, MULT accepted in the MTLO done cycle.
    do_op("mtlo_b2b", 3'd5, 32'h0000_ABCD, 32'h0, 0, m_hi, 32'h0000_ABCD);
    do_op("mult_b2b", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_7_m2", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op("divu_msb", 3'd3, 32'h8000_0000, 32'h0000_0003, 33, 32'h0000_0002, 32'h2AAA_AAAA);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
    do_op("divu_z", 3'd3, 32'h0000_0005, 32'h0000_0000, 33, 32'h0000_0005, 32'hFFFF_FFFF);
    do_op("div_z", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    do_op("nop6", 3'd6, 32'h1234_5678, 32'h9, 0, m_hi, m_lo);
    do_op("mthi", 3'd4, 32'h0000_0011, 32'h0, 0, 32'h0000_0011, m_lo);
    do_op("mtlo", 3'd5, 32'h0000_0022, 32'h0, 0, m_hi, 32'h0000_0022);
    tick();

    // cancel in IDLE blocks acceptance and changes nothing else
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_src1  = 32'h99;
    cancel    = 1'b1;
    #1;
    check("idle_cancel_ready", req_ready, 0);
    tick();
    req_valid = 1'b0;
    cancel    = 1'b0;
    check("idle_cancel_hi", hi, 32'h11);
    check("idle_cancel_done", done, 0);
    tick();

    cancel_div("cancel_c10", 10);
    cancel_div("cancel_fix", 33);

    // reset during a division clears HI/LO with no done
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_src1  = 32'h0000_0064;
    req_src2  = 32'h0000_0007;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    pulses = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    check("midrst_nodone", pulses, 0);

    // WIDTH=16 instance: DIVU 0xFFFF / 0x10, commit after 17 edges
    w_valid = 1'b1;
    w_op    = 3'd3;
    w_src1  = 16'hFFFF;
    w_src2  = 16'h0010;
    check("w16_ready", w_ready, 1);
    tick();
    w_valid = 1'b0;
    w_src1  = 16'h0;
    w_src2  = 16'h0;
    for (int unsigned i = 1; i <= 17; i++) begin
      check("w16_busy", w_busy, 1);
      check("w16_hold", {w_hi, w_lo}, 32'h0);
      tick();
    end
    check("w16_done", w_done, 1);
    check("w16_lo", w_lo, 16'h0FFF);
    check("w16_hi", w_hi, 16'h000F);
    tick();
    check("w16_done_pulse", w_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
